// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared types and constants for the instruction-fetch front end.
//   - INST_W        : instruction word width.
//   - FETCH_PC_W    : PC width of the default fetch configuration.
//   - NOP_INST      : canonical RISC-V NOP (addi x0,x0,0), available to
//                     consumers that want a benign filler instruction.
//   - fetch_entry_t : {pc, inst} pair as buffered between fetch and decode
//                     for the default PC width.
//   - fetch_ctr_w() : width of a counter that must hold 0..depth inclusive.
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int INST_W     = 32;
  localparam int FETCH_PC_W = 32;

  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_PC_W-1:0] pc;
    logic [INST_W-1:0]     inst;
  } fetch_entry_t;

  function automatic int fetch_ctr_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage : fetch_pkg

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Small synchronous FIFO used for the request-PC queue and the decoded
//   instruction queue of fetch_unit.
//
//   Parameters
//     DATA_W   entry width in bits
//     depth_p  number of entries (>= 1)
//
//   Ports
//     clk_i        clock
//     rst_i        synchronous active-high reset (pointers/count only)
//     clear_i      synchronous flush of all entries, dominates push/pop
//     push_i       write push_data_i at the tail
//     push_data_i  tail data
//     pop_i        drop the head entry
//     head_o       head entry (valid when !empty_o)
//     empty_o      no entries
//     full_o       depth_p entries
//     count_o      current occupancy, 0..depth_p
//
//   A push while full is accepted only when a pop happens in the same cycle,
//   so simultaneous push/pop works at every occupancy. A pop while empty is
//   ignored. Storage is not reset; only the pointers and count are.
// -----------------------------------------------------------------------------
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int depth_p = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               clear_i,
  input  logic                               push_i,
  input  logic [DATA_W-1:0]                  push_data_i,
  input  logic                               pop_i,
  output logic [DATA_W-1:0]                  head_o,
  output logic                               empty_o,
  output logic                               full_o,
  output logic [fetch_ctr_w(depth_p)-1:0]    count_o
);

  localparam int CNT_W = fetch_ctr_w(depth_p);
  // A single-entry FIFO still needs a 1-bit pointer to index its storage.
  localparam int PTR_W = (depth_p > 1) ? $clog2(depth_p) : 1;

  logic [DATA_W-1:0] mem [depth_p];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  cnt;
  logic              do_push;
  logic              do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(depth_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (cnt == '0);
  assign full_o  = (cnt == CNT_W'(depth_p));
  assign count_o = cnt;
  assign head_o  = mem[rd_ptr];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data_i;
  end

endmodule : fetch_fifo

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch front end between program_counter, instruction memory
//   and decode.
//
//   Parameters
//     width_p  PC / address width
//     depth_p  maximum instructions in flight (outstanding + buffered), >= 1
//
//   Ports
//     clk_i             clock
//     rst_i             synchronous active-high reset
//     pc_i              current PC from program_counter
//     stall_o           to program_counter stall_i; PC holds while high
//     flush_i           redirect, same cycle as take_branch_i
//     imem_req_valid_o  request valid
//     imem_req_addr_o   request address (= pc_i)
//     imem_req_ready_i  memory accepts the request
//     imem_rsp_valid_i  in-order response, no backpressure
//     imem_rsp_data_i   instruction word
//     inst_valid_o      instruction available to decode
//     inst_o            instruction word
//     inst_pc_o         PC of inst_o
//     inst_ready_i      decode accepts the instruction
//
//   Requests are issued only while (live outstanding + stale outstanding +
//   buffered) < depth_p, which bounds both counters and guarantees inst_q
//   room for every live response. A flush converts every live outstanding
//   request into a stale one; stale responses always arrive before live ones
//   (in-order memory), so they are simply counted off first.
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int width_p = 32,
  parameter int depth_p = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [width_p-1:0] pc_i,
  output logic               stall_o,
  input  logic               flush_i,
  output logic               imem_req_valid_o,
  output logic [width_p-1:0] imem_req_addr_o,
  input  logic               imem_req_ready_i,
  input  logic               imem_rsp_valid_i,
  input  logic [INST_W-1:0]  imem_rsp_data_i,
  output logic               inst_valid_o,
  output logic [INST_W-1:0]  inst_o,
  output logic [width_p-1:0] inst_pc_o,
  input  logic               inst_ready_i
);

  localparam int CTR_W = fetch_ctr_w(depth_p);
  // Headroom so the three-way in-flight sum cannot wrap.
  localparam int SUM_W = CTR_W + 2;

  // Same shape as fetch_entry_t, but sized by this instance's PC width.
  typedef struct packed {
    logic [width_p-1:0] pc;
    logic [INST_W-1:0]  inst;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  logic [CTR_W-1:0]   out_cnt;
  logic [CTR_W-1:0]   drop_cnt;
  logic [CTR_W-1:0]   pc_cnt;
  logic [CTR_W-1:0]   inst_cnt;
  logic [SUM_W-1:0]   inflight;
  logic               credit;
  logic               accept;
  logic               rsp_drop;
  logic               rsp_live;
  logic               q_clear;
  logic               inst_push;
  logic               inst_pop;
  logic [width_p-1:0] pc_head;
  logic               pc_empty;
  logic               pc_full;
  logic               inst_empty;
  logic               inst_full;
  entry_t             inst_push_data;
  entry_t             inst_head;

  // ---------------------------------------------------------------------------
  // Request issue
  // ---------------------------------------------------------------------------
  assign inflight = SUM_W'(out_cnt) + SUM_W'(drop_cnt) + SUM_W'(inst_cnt);
  assign credit   = (inflight < SUM_W'(depth_p));

  assign imem_req_valid_o = credit && !flush_i && !rst_i;
  assign imem_req_addr_o  = pc_i;
  assign accept           = imem_req_valid_o && imem_req_ready_i;
  // The PC only advances on a handshake, which keeps the address stable
  // while the memory is not ready.
  assign stall_o          = !accept;

  // ---------------------------------------------------------------------------
  // Response classification: stale ones are owed first
  // ---------------------------------------------------------------------------
  assign rsp_drop  = imem_rsp_valid_i && (drop_cnt != '0);
  assign rsp_live  = imem_rsp_valid_i && (drop_cnt == '0) && (out_cnt != '0);

  assign q_clear   = flush_i;
  assign inst_push = rsp_live && !flush_i;

  assign inst_push_data = '{pc: pc_head, inst: imem_rsp_data_i};

  fetch_fifo #(
    .DATA_W  (width_p),
    .depth_p (depth_p)
  ) u_pc_q (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (q_clear),
    .push_i      (accept),
    .push_data_i (pc_i),
    .pop_i       (rsp_live),
    .head_o      (pc_head),
    .empty_o     (pc_empty),
    .full_o      (pc_full),
    .count_o     (pc_cnt)
  );

  fetch_fifo #(
    .DATA_W  (ENTRY_W),
    .depth_p (depth_p)
  ) u_inst_q (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (q_clear),
    .push_i      (inst_push),
    .push_data_i (inst_push_data),
    .pop_i       (inst_pop),
    .head_o      (inst_head),
    .empty_o     (inst_empty),
    .full_o      (inst_full),
    .count_o     (inst_cnt)
  );

  // ---------------------------------------------------------------------------
  // Decode side
  // ---------------------------------------------------------------------------
  // Buffered instructions belong to the old path during a flush, so they are
  // hidden in that cycle and cleared at its end.
  assign inst_valid_o = !inst_empty && !flush_i && !rst_i;
  assign inst_pop     = inst_valid_o && inst_ready_i;
  assign inst_o       = inst_valid_o ? inst_head.inst : '0;
  assign inst_pc_o    = inst_valid_o ? inst_head.pc   : '0;

  // ---------------------------------------------------------------------------
  // Outstanding-request bookkeeping
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_cnt  <= '0;
      drop_cnt <= '0;
    end else if (flush_i) begin
      // Every live request becomes stale; a response consumed this cycle
      // (stale or live) reduces what is still owed.
      out_cnt  <= '0;
      drop_cnt <= drop_cnt + out_cnt - CTR_W'(rsp_drop || rsp_live);
    end else begin
      out_cnt  <= out_cnt + CTR_W'(accept) - CTR_W'(rsp_live);
      drop_cnt <= drop_cnt - CTR_W'(rsp_drop);
    end
  end

  // ---------------------------------------------------------------------------
  // Simulation-only invariants
  // ---------------------------------------------------------------------------
  a_no_orphan_rsp : assert property (@(posedge clk_i) disable iff (rst_i)
    imem_rsp_valid_i |-> (out_cnt != '0 || drop_cnt != '0));

  a_pc_q_tracks_out : assert property (@(posedge clk_i) disable iff (rst_i)
    pc_cnt == out_cnt);

  a_pc_q_no_underflow : assert property (@(posedge clk_i) disable iff (rst_i)
    rsp_live |-> !pc_empty);

  a_pc_q_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
    (accept && pc_full) |-> rsp_live);

  a_inst_q_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
    (inst_push && inst_full) |-> inst_pop);

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Drives fetch_unit together with a program_counter model and an in-order
//   instruction memory model with variable latency. A transaction-level model
//   (queue of in-flight requests tagged live/stale, queue of buffered
//   instructions) predicts every output each cycle. Directed sections pin the
//   model with hand-computed literals; a randomized section follows.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int W = 32;
  localparam int D = 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [W-1:0]  pc_i;
  logic          stall_o;
  logic          flush_i;
  logic          imem_req_valid_o;
  logic [W-1:0]  imem_req_addr_o;
  logic          imem_req_ready_i;
  logic          imem_rsp_valid_i;
  logic [31:0]   imem_rsp_data_i;
  logic          inst_valid_o;
  logic [31:0]   inst_o;
  logic [W-1:0]  inst_pc_o;
  logic          inst_ready_i;

  always #5 clk_i = ~clk_i;

  fetch_unit #(.width_p(W), .depth_p(D)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .pc_i             (pc_i),
    .stall_o          (stall_o),
    .flush_i          (flush_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .inst_valid_o     (inst_valid_o),
    .inst_o           (inst_o),
    .inst_pc_o        (inst_pc_o),
    .inst_ready_i     (inst_ready_i)
  );

  // Reference state
  typedef struct { logic [31:0] pc; bit stale; } fl_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } iq_t;
  typedef struct { logic [31:0] addr; int due; } mq_t;

  fl_t fl_q[$];
  iq_t iq_q[$];
  mq_t mem_q[$];

  int          cyc;
  logic [31:0] pc_m;

  // Stimulus for the next cycle
  bit          s_rst, s_flush, s_rrdy, s_irdy;
  logic [31:0] s_tgt;
  int          lat_lo, lat_hi;

  // Values sampled from the DUT in the last cycle
  logic        a_req_valid, a_stall, a_inst_valid;
  logic [31:0] a_addr, a_inst, a_inst_pc;

  // Model predictions for the current cycle
  logic        e_req_valid, e_accept, e_inst_valid;
  logic [31:0] e_inst, e_inst_pc;

  int n_chk;
  int n_fail;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive, predict, compare, then advance all models.
  task automatic step();
    bit          rsp;
    logic [31:0] rdata;
    fl_t         f;
    @(negedge clk_i);
    rsp   = !s_rst && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    rdata = rsp ? mem_word(mem_q[0].addr) : $urandom();
    rst_i            = s_rst;
    flush_i          = s_flush;
    imem_req_ready_i = s_rrdy;
    inst_ready_i     = s_irdy;
    pc_i             = pc_m;
    imem_rsp_valid_i = rsp;
    imem_rsp_data_i  = rdata;

    e_req_valid  = !s_rst && !s_flush && ((fl_q.size() + iq_q.size()) < D);
    e_accept     = e_req_valid && s_rrdy;
    e_inst_valid = !s_rst && !s_flush && (iq_q.size() > 0);
    e_inst       = e_inst_valid ? iq_q[0].inst : 32'h0;
    e_inst_pc    = e_inst_valid ? iq_q[0].pc   : 32'h0;

    #1;
    a_req_valid  = imem_req_valid_o;
    a_addr       = imem_req_addr_o;
    a_stall      = stall_o;
    a_inst_valid = inst_valid_o;
    a_inst       = inst_o;
    a_inst_pc    = inst_pc_o;
    chk("req_valid",  {31'b0, a_req_valid},  {31'b0, e_req_valid});
    chk("req_addr",   a_addr,                pc_m);
    chk("stall",      {31'b0, a_stall},      {31'b0, !e_accept});
    chk("inst_valid", {31'b0, a_inst_valid}, {31'b0, e_inst_valid});
    chk("inst",       a_inst,                e_inst);
    chk("inst_pc",    a_inst_pc,             e_inst_pc);

    @(posedge clk_i);
    if (s_rst) begin
      fl_q.delete();
      iq_q.delete();
      mem_q.delete();
      pc_m = 32'h0;
    end else begin
      if (e_inst_valid && s_irdy) void'(iq_q.pop_front());
      if (rsp) begin
        void'(mem_q.pop_front());
        f = fl_q.pop_front();
        if (!f.stale && !s_flush) iq_q.push_back('{pc: f.pc, inst: rdata});
      end
      if (s_flush) begin
        iq_q.delete();
        foreach (fl_q[i]) fl_q[i].stale = 1'b1;
      end
      if (e_accept) begin
        fl_q.push_back('{pc: pc_m, stale: 1'b0});
        mem_q.push_back('{addr: pc_m, due: cyc + int'($urandom_range(lat_hi, lat_lo))});
      end
      if (s_flush)       pc_m = s_tgt;
      else if (e_accept) pc_m = pc_m + 32'd4;
    end
    cyc++;
  endtask

  task automatic do_reset();
    s_rst = 1'b1; s_flush = 1'b0;
    step();
    step();
    s_rst = 1'b0;
  endtask

  // Let every outstanding response come back and decode drain the buffer.
  task automatic drain();
    s_rrdy = 1'b0; s_irdy = 1'b1; s_flush = 1'b0;
    repeat (10) step();
  endtask

  // Step until decode sees a valid instruction; expiry counts as a failure.
  task automatic wait_inst(input string name, input logic [31:0] exp_pc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step();
      seen = a_inst_valid;
    end
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s timeout: no instruction, expected pc %h", name, exp_pc);
    end else begin
      chk({name, "_pc"},   a_inst_pc, exp_pc);
      chk({name, "_data"}, a_inst,    mem_word(exp_pc));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; pc_m = 32'h0;
    rst_i = 1'b1; flush_i = 1'b0; pc_i = '0; imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0; imem_rsp_data_i = '0; inst_ready_i = 1'b0;
    s_rst = 1'b1; s_flush = 1'b0; s_tgt = 32'h0; s_rrdy = 1'b1; s_irdy = 1'b1;
    lat_lo = 1; lat_hi = 1;

    // Streaming after reset, 1-cycle memory.
    do_reset();
    chk("rst_req_valid",  {31'b0, a_req_valid},  32'd0);
    chk("rst_stall",      {31'b0, a_stall},      32'd1);
    chk("rst_inst_valid", {31'b0, a_inst_valid}, 32'd0);
    step();
    chk("first_req", {31'b0, a_req_valid}, 32'd1);
    chk("first_addr", a_addr, 32'h0);
    step();
    chk("second_addr", a_addr, 32'h4);
    step();
    chk("first_inst_valid", {31'b0, a_inst_valid}, 32'd1);
    chk("first_inst_pc", a_inst_pc, 32'h0);
    chk("first_inst", a_inst, mem_word(32'h0));
    repeat (20) step();

    // Decode stalled: credit stops issue at two in flight.
    do_reset();
    s_irdy = 1'b0;
    repeat (6) step();
    chk("full_req_valid",  {31'b0, a_req_valid},  32'd0);
    chk("full_stall",      {31'b0, a_stall},      32'd1);
    chk("full_head_pc",    a_inst_pc,             32'h0);
    s_irdy = 1'b1;
    step();
    chk("resume_pop_req_valid", {31'b0, a_req_valid}, 32'd0);
    step();
    chk("resume_req_valid", {31'b0, a_req_valid}, 32'd1);
    chk("resume_addr", a_addr, 32'h8);
    chk("resume_head_pc", a_inst_pc, 32'h4);

    // Memory not ready for 3 cycles at 0x10.
    drain();
    s_flush = 1'b1; s_tgt = 32'h10;
    step();
    chk("flush_req_valid",  {31'b0, a_req_valid},  32'd0);
    chk("flush_stall",      {31'b0, a_stall},      32'd1);
    s_flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("nordy_stall", {31'b0, a_stall}, 32'd1);
      chk("nordy_addr", a_addr, 32'h10);
      chk("nordy_no_inst", {31'b0, a_inst_valid}, 32'd0);
    end
    s_rrdy = 1'b1;
    wait_inst("after_nordy", 32'h10);

    // Two outstanding at 0x20/0x24 discarded by a redirect to 0x100.
    drain();
    lat_lo = 3; lat_hi = 3;
    s_flush = 1'b1; s_tgt = 32'h20;
    step();
    s_flush = 1'b0; s_rrdy = 1'b1;
    step();
    chk("out0_addr", a_addr, 32'h20);
    step();
    chk("out1_addr", a_addr, 32'h24);
    chk("out1_req_valid", {31'b0, a_req_valid}, 32'd1);
    s_flush = 1'b1; s_tgt = 32'h100;
    step();
    s_flush = 1'b0;
    wait_inst("redirect", 32'h100);

    // Response lands in the flush cycle with one more still owed.
    drain();
    s_flush = 1'b1; s_tgt = 32'h40;
    step();
    s_flush = 1'b0; s_rrdy = 1'b1; s_irdy = 1'b0;
    repeat (3) step();
    s_flush = 1'b1; s_tgt = 32'h80;
    step();
    chk("rspflush_inst_valid", {31'b0, a_inst_valid}, 32'd0);
    s_flush = 1'b0;
    step();
    chk("postflush_inst_valid", {31'b0, a_inst_valid}, 32'd0);
    s_irdy = 1'b1;
    wait_inst("after_rspflush", 32'h80);

    // Reset in the middle of traffic.
    drain();
    s_rrdy = 1'b1; s_irdy = 1'b0;
    repeat (4) step();
    do_reset();
    chk("midrst_req_valid",  {31'b0, a_req_valid},  32'd0);
    chk("midrst_stall",      {31'b0, a_stall},      32'd1);
    chk("midrst_inst_valid", {31'b0, a_inst_valid}, 32'd0);
    chk("midrst_inst",       a_inst,                32'd0);
    chk("midrst_inst_pc",    a_inst_pc,             32'd0);
    s_rrdy = 1'b1; s_irdy = 1'b1;
    step();
    chk("midrst_first_addr", a_addr, 32'h0);
    chk("midrst_first_req", {31'b0, a_req_valid}, 32'd1);

    // Randomized traffic.
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 4000; i++) begin
      s_rst   = ($urandom_range(299, 0) == 0);
      s_flush = ($urandom_range(15, 0) == 0);
      s_tgt   = $urandom() & 32'hFFFF_FFFC;
      s_rrdy  = ($urandom_range(3, 0) != 0);
      s_irdy  = ($urandom_range(3, 0) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_fetch_unit
